// File: rtl/multicycle_mem_responder.sv
// multicycle_mem_responder
// Fixed-latency 16-bit word memory. One request per cycle, no backpressure.
// Writes commit at the sampling edge; reads capture the stored word at the
// acceptance edge (read-before-write) and travel down a LATENCY-deep
// {valid, data, addr} shift pipeline whose last stage drives the response.
//
// Handshake: there is no ready. A request is taken on every rising edge
// where enable=1 and rst=0. data_valid is a one-cycle strobe per accepted
// read; data_out/addr_out are meaningful only while data_valid=1 and hold
// the most recent response otherwise.
module multicycle_mem_responder #(
  parameter int LATENCY        = 4,
  parameter int WORD_ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [15:0] addr_out,
  output logic [3:0]  pending
);

  localparam int DEPTH = 1 << WORD_ADDR_BITS;

  // Storage is deliberately not reset; contents survive rst.
  logic [15:0] mem [DEPTH];

  logic [WORD_ADDR_BITS-1:0] word_idx;
  logic                      rd_accept;
  logic                      wr_accept;

  logic [LATENCY-1:0] stg_valid;
  logic [15:0]        stg_data [LATENCY];
  logic [15:0]        stg_addr [LATENCY];

  logic [LATENCY-1:0] in_valid;
  logic [15:0]        in_data [LATENCY];
  logic [15:0]        in_addr [LATENCY];

  // addr[0] and bits above the word index are dropped, so addresses alias.
  assign word_idx  = addr[WORD_ADDR_BITS:1];
  assign rd_accept = enable & ~wr;
  assign wr_accept = enable & wr;

  // Stage inputs: stage 0 takes the new read, later stages take their predecessor.
  always_comb begin
    in_valid[0] = rd_accept;
    in_data[0]  = mem[word_idx];
    in_addr[0]  = addr;
    for (int i = 1; i < LATENCY; i++) begin
      in_valid[i] = stg_valid[i-1];
      in_data[i]  = stg_data[i-1];
      in_addr[i]  = stg_addr[i-1];
    end
  end

  // Write port; the old word is already on in_data[0] for a read at this edge.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      mem[word_idx] <= data_in;
    end
  end

  // Response pipeline; payload loads only with a valid entry so the last stage holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_data[i] <= 16'h0000;
        stg_addr[i] <= 16'h0000;
      end
    end else begin
      stg_valid <= in_valid;
      for (int i = 0; i < LATENCY; i++) begin
        if (in_valid[i]) begin
          stg_data[i] <= in_data[i];
          stg_addr[i] <= in_addr[i];
        end
      end
    end
  end

  // Outstanding-read count: up on accept, down on the returning cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 4'd0;
    end else begin
      case ({rd_accept, data_valid})
        2'b10:   pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

  assign data_valid = stg_valid[LATENCY-1];
  assign data_out   = stg_data[LATENCY-1];
  assign addr_out   = stg_addr[LATENCY-1];

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// tb_multicycle_mem_responder
// Drives directed and random traffic into multicycle_mem_responder and
// compares every cycle against a reference built from a plain word array
// and a queue of scheduled responses (due cycle, data, address).
module tb_multicycle_mem_responder;

  localparam int LATENCY = 4;
  localparam int WAB     = 10;
  localparam int DEPTH   = 1 << WAB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] data_out;
  logic        data_valid;
  logic [15:0] addr_out;
  logic [3:0]  pending;

  multicycle_mem_responder #(
    .LATENCY        (LATENCY),
    .WORD_ADDR_BITS (WAB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .addr_out   (addr_out),
    .pending    (pending)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int max_pend = 0;
  int n_valid_seen = 0;

  logic [15:0] model_mem [DEPTH];
  logic [15:0] exp_q[$];
  logic [15:0] exp_addr_q[$];
  int          exp_due_q[$];
  logic [15:0] exp_last_data = 16'h0000;
  logic [15:0] exp_last_addr = 16'h0000;

  function automatic int word_of(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare this cycle's outputs with what the schedule says.
  task automatic check_outputs();
    logic exp_valid;
    exp_valid = (exp_due_q.size() > 0) && (exp_due_q[0] == cyc);
    check_eq("pending", {28'd0, pending}, exp_due_q.size());
    if (int'(pending) > max_pend) max_pend = int'(pending);
    if (exp_valid) begin
      void'(exp_due_q.pop_front());
      exp_last_data = exp_q.pop_front();
      exp_last_addr = exp_addr_q.pop_front();
    end
    if (data_valid === 1'b1) n_valid_seen++;
    check_eq("data_valid", {31'd0, data_valid}, {31'd0, exp_valid});
    check_eq("data_out", {16'd0, data_out}, {16'd0, exp_last_data});
    check_eq("addr_out", {16'd0, addr_out}, {16'd0, exp_last_addr});
  endtask

  // ---------------- driver tasks ----------------
  // Present one request for one cycle; called at posedge+1.
  task automatic step(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    cyc++;
    if (en && !w) begin
      exp_due_q.push_back(cyc - 1 + LATENCY);
      exp_q.push_back(model_mem[word_of(a)]);
      exp_addr_q.push_back(a);
    end else if (en && w) begin
      model_mem[word_of(a)] = d;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Asynchronous reset for n cycles with read requests toggling underneath.
  task automatic do_reset(input int n);
    rst    = 1'b1;
    enable = 1'b1;
    wr     = 1'b0;
    addr   = 16'($urandom);
    #1;
    exp_q.delete();
    exp_addr_q.delete();
    exp_due_q.delete();
    exp_last_data = 16'h0000;
    exp_last_addr = 16'h0000;
    check_outputs();
    for (int i = 0; i < n; i++) begin
      enable = ~enable;
      @(posedge clk);
      cyc++;
      #1;
      check_outputs();
    end
    rst    = 1'b0;
    enable = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int vbefore;

    @(posedge clk);
    #1;
    do_reset(2);
    idle(LATENCY + 2);

    // Fill every word so random reads always have a defined expectation.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 16'(i * 2), 16'($urandom));

    // Single write then read: response LATENCY cycles after the read.
    step(1'b1, 1'b1, 16'h0024, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0024, 16'h0000);
    idle(LATENCY - 1);
    check_eq("single_valid", {31'd0, data_valid}, 32'd1);
    check_eq("single_data", {16'd0, data_out}, 32'h0000_BEEF);
    check_eq("single_addr", {16'd0, addr_out}, 32'h0000_0024);
    idle(2);

    // Write-then-read ordering on one word, with output hold in between.
    step(1'b1, 1'b1, 16'h0010, 16'h1111);
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    step(1'b1, 1'b1, 16'h0010, 16'h2222);
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(LATENCY - 3);
    check_eq("hazard_old", {16'd0, data_out}, 32'h0000_1111);
    idle(1);
    check_eq("hazard_hold", {16'd0, data_out}, 32'h0000_1111);
    idle(1);
    check_eq("hazard_new", {16'd0, data_out}, 32'h0000_2222);
    idle(2);

    // Cache-fill burst: 8 stride-2 reads back to back.
    for (int j = 0; j < 8; j++) step(1'b1, 1'b1, 16'(16'h4000 + 2 * j), 16'(16'hA000 + j));
    max_pend = 0;
    vbefore  = n_valid_seen;
    for (int j = 0; j < 8; j++) step(1'b1, 1'b0, 16'(16'h4000 + 2 * j), 16'h0000);
    idle(LATENCY + 2);
    check_eq("burst_peak", max_pend, LATENCY);
    check_eq("burst_count", n_valid_seen - vbefore, 8);
    check_eq("burst_last", {16'd0, data_out}, 32'h0000_A007);
    check_eq("burst_drain", {28'd0, pending}, 32'd0);

    // Aliasing through dropped address bits.
    step(1'b1, 1'b1, 16'h0002, 16'h1234);
    step(1'b1, 1'b0, 16'h0803, 16'h0000);
    idle(LATENCY - 1);
    check_eq("alias_data", {16'd0, data_out}, 32'h0000_1234);
    check_eq("alias_addr", {16'd0, addr_out}, 32'h0000_0803);
    idle(2);

    // Reset mid-burst discards in-flight reads but keeps storage.
    vbefore = n_valid_seen;
    step(1'b1, 1'b0, 16'h4000, 16'h0000);
    step(1'b1, 1'b0, 16'h4002, 16'h0000);
    do_reset(1);
    idle(LATENCY + 2);
    check_eq("midrst_valids", n_valid_seen - vbefore, 0);
    check_eq("midrst_pending", {28'd0, pending}, 32'd0);
    step(1'b1, 1'b0, 16'h4004, 16'h0000);
    idle(LATENCY - 1);
    check_eq("postrst_valid", {31'd0, data_valid}, 32'd1);
    check_eq("postrst_data", {16'd0, data_out}, 32'h0000_A002);
    idle(2);

    // Random mix of reads, writes, idles and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             16'($urandom), 16'($urandom));
      end
    end
    idle(LATENCY + 2);
    check_eq("final_pending", {28'd0, pending}, 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
